// File: rtl/axi_pkg.sv
// Shared AXI read-side types and constants: burst encodings, response codes,
// and the legality check applied to every captured read request.
package axi_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 64;

   localparam logic [2:0] SUPPORTED_SIZE = 3'd3;
   localparam logic [1:0] OKAY           = 2'b00;
   localparam logic [1:0] SLVERR         = 2'b10;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } axi_burst_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } rd_state_e;

   // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
   function automatic logic burst_is_err(input logic [2:0] size,
                                         input logic [1:0] burst,
                                         input logic [7:0] len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (size != SUPPORTED_SIZE) || (burst == 2'b11) ||
             ((burst == WRAP) && !wrap_len_ok);
   endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AXI4 read address / read data channel bundle between an initiator and the responder.
interface axi_read_responder_if;
   import axi_pkg::*;

   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP bursts of 8-byte beats.
module axi_burst_addr_gen
   import axi_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] wrap_mask;

   always_comb begin
      incr_addr = addr + ADDR_W'(8);
      // Legal wrap lengths are 2^n-1, so {len,3'b111} is the byte mask of the wrap window.
      wrap_mask = {{(ADDR_W-11){1'b0}}, len, 3'b111};
      case (burst)
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default: next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-only responder over an inferred 64-bit memory with a side preload port.
// One burst at a time: IDLE accepts AR, WAIT models access latency, BURST streams beats.
module axi_read_responder
   import axi_pkg::*;
#(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   axi_read_responder_if.slave          s_axi,
   input  logic                         init_we,
   input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
   input  logic [DATA_W-1:0]            init_data
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   rd_state_e         state_q, state_d;
   logic [3:0]        lat_cnt_q, lat_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_next;
   logic [7:0]        len_q, len_d;
   logic [7:0]        beat_idx_q, beat_idx_d;
   logic [1:0]        burst_q, burst_d;
   logic              err_q, err_d;
   logic              load_beat;

   logic              vld_p0, vld_d;
   logic [1:0]        resp_p0, resp_d;
   logic              last_p0, last_d;
   logic [DATA_W-1:0] data_p0;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   axi_burst_addr_gen u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (addr_next)
   );

   assign s_axi.arready = (state_q == IDLE) && !reset;
   assign s_axi.rvalid  = vld_p0;
   assign s_axi.rdata   = data_p0;
   assign s_axi.rresp   = resp_p0;
   assign s_axi.rlast   = last_p0;

   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      addr_d     = addr_q;
      len_d      = len_q;
      burst_d    = burst_q;
      err_d      = err_q;
      beat_idx_d = beat_idx_q;
      vld_d      = vld_p0;
      resp_d     = resp_p0;
      last_d     = last_p0;
      load_beat  = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_axi.arvalid) begin
               addr_d     = s_axi.araddr;
               len_d      = s_axi.arlen;
               burst_d    = s_axi.arburst;
               err_d      = burst_is_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);
               beat_idx_d = 8'd0;
               lat_cnt_d  = 4'd0;
               state_d    = (READ_LATENCY == 0) ? BURST : WAIT;
            end
         end
         WAIT: begin
            if ({28'd0, lat_cnt_q} + 32'd1 >= READ_LATENCY) begin
               state_d = BURST;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         BURST: begin
            // A free output slot (empty or being consumed) is refilled in the same edge.
            if (!vld_p0 || s_axi.rready) begin
               if (vld_p0 && last_p0) begin
                  state_d = IDLE;
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  load_beat  = 1'b1;
                  vld_d      = 1'b1;
                  resp_d     = err_q ? SLVERR : OKAY;
                  last_d     = (beat_idx_q == len_q);
                  addr_d     = addr_next;
                  beat_idx_d = beat_idx_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         lat_cnt_q  <= '0;
         beat_idx_q <= '0;
         vld_p0     <= 1'b0;
         resp_p0    <= OKAY;
         last_p0    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         beat_idx_q <= beat_idx_d;
         vld_p0     <= vld_d;
         resp_p0    <= resp_d;
         last_p0    <= last_d;
      end
   end

   always_ff @(posedge clock) begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      err_q   <= err_d;
   end

   // Preload is independent of the FSM; a read in the same edge sees the old word.
   always_ff @(posedge clock) begin
      if (init_we) begin
         mem[init_addr] <= init_data;
      end
   end

   // ---- stage p0: beat data register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         data_p0 <= '0;
      end else if (load_beat) begin
         data_p0 <= err_q ? '0 : mem[addr_q[3 +: IDX_W]];
      end
   end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: latency 2 and latency 0 instances share stimulus.
module tb_axi_read_responder;

   logic        clock;
   logic        reset;
   logic        init_we;
   logic [9:0]  init_addr;
   logic [63:0] init_data;

   logic        ar_valid;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_ready;
   logic        sel0;

   logic        ar_ready;
   logic        r_valid;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [63:0] got_data [32];
   logic [1:0]  got_resp [32];
   logic        got_last [32];
   int          n_beats;
   int          first_lat;
   int          stall_bad;
   logic        arready_after;
   logic        rvalid_after;
   logic [63:0] exp_q [$];

   axi_read_responder_if bus2 ();
   axi_read_responder_if bus0 ();

   assign bus2.arvalid = ar_valid & ~sel0;
   assign bus0.arvalid = ar_valid & sel0;
   assign bus2.araddr  = ar_addr;
   assign bus0.araddr  = ar_addr;
   assign bus2.arlen   = ar_len;
   assign bus0.arlen   = ar_len;
   assign bus2.arsize  = ar_size;
   assign bus0.arsize  = ar_size;
   assign bus2.arburst = ar_burst;
   assign bus0.arburst = ar_burst;
   assign bus2.rready  = r_ready;
   assign bus0.rready  = r_ready;

   assign ar_ready = sel0 ? bus0.arready : bus2.arready;
   assign r_valid  = sel0 ? bus0.rvalid  : bus2.rvalid;
   assign r_data   = sel0 ? bus0.rdata   : bus2.rdata;
   assign r_resp   = sel0 ? bus0.rresp   : bus2.rresp;
   assign r_last   = sel0 ? bus0.rlast   : bus2.rlast;

   axi_read_responder #(.MEM_WORDS(1024), .READ_LATENCY(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .s_axi     (bus2),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   axi_read_responder #(.MEM_WORDS(1024), .READ_LATENCY(0)) dut_lat0 (
      .clock     (clock),
      .reset     (reset),
      .s_axi     (bus0),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic mem_write(input logic [9:0] a, input logic [63:0] d);
      init_we   = 1'b1;
      init_addr = a;
      init_data = d;
      @(negedge clock);
      init_we   = 1'b0;
   endtask

   // Returns at the negedge just after the AR handshake edge.
   task automatic issue(input logic [63:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int guard;
      guard    = 0;
      ar_addr  = a;
      ar_len   = len;
      ar_size  = size;
      ar_burst = burst;
      ar_valid = 1'b1;
      while (!ar_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (!ar_ready) check("ar_timeout", 64'd0, 64'd1);
      @(posedge clock);
      @(negedge clock);
      ar_valid = 1'b0;
   endtask

   // rr_pat bit i is rready for the i-th cycle with rvalid high; a preload write
   // is issued on cycle wr_idx of that sequence.
   task automatic collect(input logic [15:0] rr_pat, input int pat_len, input int wr_idx,
                          input logic [9:0] wr_addr, input logic [63:0] wr_data);
      int          cyc;
      int          idx;
      bit          done;
      bit          held;
      logic [63:0] h_data;
      logic [1:0]  h_resp;
      logic        h_last;
      n_beats   = 0;
      first_lat = -1;
      stall_bad = 0;
      cyc       = 0;
      idx       = 0;
      done      = 1'b0;
      held      = 1'b0;
      h_data    = '0;
      h_resp    = '0;
      h_last    = 1'b0;
      while (!done && cyc < 100) begin
         init_we = 1'b0;
         if (r_valid) begin
            if (first_lat < 0) first_lat = cyc;
            if (held && (r_data !== h_data || r_resp !== h_resp || r_last !== h_last)) stall_bad++;
            r_ready = (idx < pat_len) ? rr_pat[idx[3:0]] : 1'b1;
            if (idx == wr_idx) begin
               init_we   = 1'b1;
               init_addr = wr_addr;
               init_data = wr_data;
            end
            idx++;
            h_data = r_data;
            h_resp = r_resp;
            h_last = r_last;
            held   = !r_ready;
            if (r_ready) begin
               if (n_beats < 32) begin
                  got_data[n_beats] = r_data;
                  got_resp[n_beats] = r_resp;
                  got_last[n_beats] = r_last;
               end
               n_beats++;
               done = r_last;
            end
         end else begin
            r_ready = 1'b1;
         end
         @(negedge clock);
         cyc++;
      end
      init_we = 1'b0;
      r_ready = 1'b1;
      if (!done) check("burst_timeout", 64'd0, 64'd1);
      arready_after = ar_ready;
      rvalid_after  = r_valid;
   endtask

   task automatic verify(input string tag, input int exp_lat, input logic [1:0] exp_resp);
      check({tag, "_lat"}, 64'(first_lat), 64'(exp_lat));
      check({tag, "_nbeats"}, 64'(n_beats), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n_beats && i < 32; i++) begin
         check($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
         check($sformatf("%s_resp%0d", tag, i), 64'(got_resp[i]), 64'(exp_resp));
         check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == exp_q.size() - 1));
      end
      check({tag, "_arready_after"}, 64'(arready_after), 64'd1);
      check({tag, "_rvalid_after"}, 64'(rvalid_after), 64'd0);
   endtask

   initial begin
      int cnt;
      int guard;
      reset     = 1'b1;
      init_we   = 1'b0;
      init_addr = '0;
      init_data = '0;
      ar_valid  = 1'b0;
      ar_addr   = '0;
      ar_len    = '0;
      ar_size   = 3'd3;
      ar_burst  = 2'd1;
      r_ready   = 1'b1;
      sel0      = 1'b0;

      repeat (3) @(negedge clock);
      check("rst_arready_held_low", 64'(ar_ready), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_arready", 64'(ar_ready), 64'd1);
      check("rst_rvalid", 64'(r_valid), 64'd0);
      check("rst_rlast", 64'(r_last), 64'd0);
      check("rst_rresp", 64'(r_resp), 64'd0);
      check("rst_rdata", r_data, 64'd0);

      for (int k = 0; k < 1024; k++) mem_write(10'(k), 64'(k));

      issue(64'h40, 8'd3, 3'd3, 2'd1);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd8, 64'd9, 64'd10, 64'd11};
      verify("incr", 3, 2'b00);

      issue(64'h1028, 8'd7, 3'd3, 2'd2);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'h205, 64'h206, 64'h207, 64'h200, 64'h201, 64'h202, 64'h203, 64'h204};
      verify("wrap", 3, 2'b00);

      // Stall pattern 1,0,0,1,0,1,1; word 9 is overwritten while beat 1 is already held.
      issue(64'h40, 8'd3, 3'd3, 2'd1);
      collect(16'h0069, 7, 1, 10'd9, 64'h999);
      exp_q = '{64'd8, 64'd9, 64'd10, 64'd11};
      verify("bp", 3, 2'b00);
      check("bp_stable", 64'(stall_bad), 64'd0);
      mem_write(10'd9, 64'd9);

      issue(64'h40, 8'd3, 3'd2, 2'd1);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd0, 64'd0, 64'd0, 64'd0};
      verify("err_size", 3, 2'b10);

      issue(64'h40, 8'd5, 3'd3, 2'd2);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      verify("err_wrap5", 3, 2'b10);

      issue(64'h40, 8'd0, 3'd3, 2'd3);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd0};
      verify("err_rsvd", 3, 2'b10);

      issue(64'h2040, 8'd0, 3'd3, 2'd1);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd8};
      verify("addr_mod", 3, 2'b00);

      issue(64'h50, 8'd2, 3'd3, 2'd0);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd10, 64'd10, 64'd10};
      verify("fixed", 3, 2'b00);

      // Reset while beat 2 of an 8-beat INCR burst is on the bus.
      issue(64'h40, 8'd7, 3'd3, 2'd1);
      cnt   = 0;
      guard = 0;
      while (cnt < 2 && guard < 50) begin
         if (r_valid && r_ready) cnt++;
         @(negedge clock);
         guard++;
      end
      check("rst_mid_two_beats", 64'(cnt), 64'd2);
      check("rst_mid_beat2_data", r_data, 64'd10);
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_rvalid", 64'(r_valid), 64'd0);
      check("rst_mid_arready", 64'(ar_ready), 64'd0);
      @(negedge clock);
      check("rst_mid_rvalid_hold", 64'(r_valid), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rst_mid_arready_rel", 64'(ar_ready), 64'd1);
      check("rst_mid_rdata_rel", r_data, 64'd0);
      issue(64'h48, 8'd1, 3'd3, 2'd1);
      collect(16'h0000, 0, -1, 10'd0, 64'd0);
      exp_q = '{64'd9, 64'd10};
      verify("post_rst", 3, 2'b00);

      // Zero-latency instance: word 11 (beat 3) rewritten during the stall on beat 1.
      sel0 = 1'b1;
      @(negedge clock);
      issue(64'h40, 8'd3, 3'd3, 2'd1);
      collect(16'h0039, 6, 1, 10'd11, 64'hBEEF);
      exp_q = '{64'd8, 64'd9, 64'd10, 64'hBEEF};
      verify("lat0", 1, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
